i2c_master_arb: RTL and testbench

Two-requester I2C master that shares one open-drain I2C bus (e.g. for driving LED slaves at 7'h4A) between two on-chip requesters. Each request is a single-byte write: START, 7-bit address + W, ACK, data byte, ACK, STOP. A round-robin arbiter picks the requester, a bit-level FSM generates SCL/SDA, and the block reports completion and NACK status back to the granted requester. Sits between on-chip command sources and the uio pads; drivers follow the top-level convention uio_oe = ~x_o.

---
 rtl/i2c_master_arb.sv | 164 ++++++++++++++++
 tb/tb_i2c_master_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arb.sv
// Two-requester, single-byte-write I2C master with round-robin grant.
// Each transfer is START, {addr,W}, ACK, data, ACK, STOP; SCL/SDA are open-drain style (1 = release).
module i2c_master_arb #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_Q   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [6:0] addr0_i,
  input  logic [7:0] data0_i,
  input  logic [6:0] addr1_i,
  input  logic [7:0] data1_i,
  output logic [1:0] gnt_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_ACK1  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_ACK2  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int unsigned GAP_CYC = GAP_Q * CLK_DIV;
  localparam int unsigned GW      = $clog2(GAP_CYC + 2);

  logic [2:0]    state;
  logic [1:0]    qtr;
  logic [7:0]    tcnt;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic [7:0]    dbyte;
  logic [1:0]    gnt;
  logic          nack;
  logic          prio1;
  logic [GW-1:0] gap;
  logic          stall;
  logic          qend;

  // A released SCL that the bus still holds low freezes the quarter timer.
  assign stall = scl_o & ~scl_i;
  assign qend  = ~stall && (tcnt == 8'(CLK_DIV - 1));

  assign gnt_o  = gnt;
  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign nack_o = nack;

  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (state)
      S_START: sda_o = 1'b0;
      S_ADDR, S_DATA: begin
        scl_o = qtr[1];
        sda_o = shreg[7];
      end
      S_ACK1, S_ACK2: scl_o = qtr[1];
      S_STOP: begin
        scl_o = (qtr != 2'd0);
        sda_o = (qtr == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      qtr   <= '0;
      tcnt  <= '0;
      bitn  <= '0;
      shreg <= '0;
      dbyte <= '0;
      gnt   <= '0;
      nack  <= 1'b0;
      prio1 <= 1'b0;
      gap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tcnt <= '0;
          qtr  <= '0;
          bitn <= '0;
          if (gap != '0) begin
            gap <= gap - 1'b1;
          end else if (req_i != 2'b00) begin
            state <= S_START;
            nack  <= 1'b0;
            if (req_i[0] && (!req_i[1] || !prio1)) begin
              gnt   <= 2'b01;
              shreg <= {addr0_i, 1'b0};
              dbyte <= data0_i;
            end else begin
              gnt   <= 2'b10;
              shreg <= {addr1_i, 1'b0};
              dbyte <= data1_i;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= '0;
          qtr   <= '0;
          prio1 <= gnt[0];
          gap   <= GW'(GAP_CYC);
        end
        default: begin
          if (stall)     tcnt <= '0;
          else if (qend) tcnt <= '0;
          else           tcnt <= tcnt + 8'd1;
          // qtr advances every quarter; state changes below override it to 0.
          if (qend) begin
            qtr <= qtr + 2'd1;
            case (state)
              S_START: if (qtr == 2'd1) begin
                state <= S_ADDR;
                qtr   <= '0;
                bitn  <= '0;
              end
              S_ADDR, S_DATA: if (qtr == 2'd3) begin
                qtr   <= '0;
                shreg <= {shreg[6:0], 1'b0};
                bitn  <= bitn + 3'd1;
                if (bitn == 3'd7) state <= (state == S_ADDR) ? S_ACK1 : S_ACK2;
              end
              S_ACK1: if (qtr == 2'd3) begin
                qtr <= '0;
                if (sda_i) begin
                  nack  <= 1'b1;
                  state <= S_STOP;
                end else begin
                  state <= S_DATA;
                  shreg <= dbyte;
                  bitn  <= '0;
                end
              end
              S_ACK2: if (qtr == 2'd3) begin
                qtr   <= '0;
                state <= S_STOP;
                if (sda_i) nack <= 1'b1;
              end
              S_STOP: if (qtr == 2'd2) begin
                qtr   <= '0;
                state <= S_DONE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arb.sv
// Randomized bench for i2c_master_arb: a byte-level I2C slave model plus a
// transaction-level reference (round-robin order, expected bytes, latency, NACK).
module tb_i2c_master_arb;

  localparam int CLK_DIV = 4;
  localparam int GAP_Q   = 2;
  localparam int STRETCH = 20;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [6:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic [1:0] gnt;
  logic       busy, done, nack;
  logic       scl_i, scl_o, sda_i, sda_o;

  i2c_master_arb #(.CLK_DIV(CLK_DIV), .GAP_Q(GAP_Q)) dut (
    .clk(clk), .reset(reset), .req_i(req),
    .addr0_i(addr0), .data0_i(data0), .addr1_i(addr1), .data1_i(data1),
    .gnt_o(gnt), .busy_o(busy), .done_o(done), .nack_o(nack),
    .scl_i(scl_i), .scl_o(scl_o), .sda_i(sda_i), .sda_o(sda_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave model: decodes bytes on SCL rises, optionally ACKs, optionally stretches one SCL high phase.
  logic       ack_addr, ack_data, stretch_req;
  logic       scl_prev, sda_prev, pull, in_ack, st_used;
  logic [7:0] sh;
  int         bitpos, rise_cnt, nbyte, stretch_left;
  logic [7:0] rx[$];

  assign scl_i = scl_o & (stretch_left == 0);
  assign sda_i = sda_o & ~pull;

  always @(posedge clk) begin
    scl_prev <= scl_i;
    sda_prev <= sda_i;
    if (reset) begin
      bitpos <= 0; rise_cnt <= 0; nbyte <= 0; stretch_left <= 0;
      pull <= 1'b0; in_ack <= 1'b0; st_used <= 1'b0; sh <= '0;
    end else begin
      if (stretch_left != 0 && scl_o)
        stretch_left <= stretch_left - 1;
      else if (stretch_req && !st_used && !scl_i && rise_cnt == 3) begin
        stretch_left <= STRETCH;
        st_used <= 1'b1;
      end
      if (scl_prev && scl_i && sda_prev && !sda_i) begin
        bitpos <= 0; rise_cnt <= 0; nbyte <= 0;
        in_ack <= 1'b0; pull <= 1'b0; st_used <= 1'b0;
      end else if (!scl_prev && scl_i) begin
        rise_cnt <= rise_cnt + 1;
        if (!in_ack) begin
          sh <= {sh[6:0], sda_i};
          bitpos <= bitpos + 1;
        end
      end else if (scl_prev && !scl_i) begin
        if (in_ack) begin
          in_ack <= 1'b0;
          pull <= 1'b0;
          bitpos <= 0;
        end else if (bitpos == 8) begin
          in_ack <= 1'b1;
          rx.push_back(sh);
          pull <= (nbyte == 0) ? ack_addr : ack_data;
          nbyte <= nbyte + 1;
        end
      end
    end
  end

  // Reference state: who was served last, and when the last transfer finished.
  int last_srv = 1;
  int last_done_cyc = 0;
  bit have_done = 0;

  function automatic logic [1:0] exp_grant(input logic [1:0] r);
    if (r == 2'b11) return (last_srv == 0) ? 2'b10 : 2'b01;
    return r;
  endfunction

  // mode: 0 = both ACKed, 1 = address NACKed, 2 = data NACKed
  task automatic do_txn(input logic [1:0] r, input logic [6:0] a0, input logic [7:0] d0,
                        input logic [6:0] a1, input logic [7:0] d1,
                        input int mode, input bit stretch, input bit perturb);
    int t, gcyc, dcyc, exp_lat;
    logic [1:0] eg;
    logic [6:0] ea;
    logic [7:0] ed;
    addr0 = a0; data0 = d0; addr1 = a1; data1 = d1;
    ack_addr = (mode != 1);
    ack_data = (mode != 2);
    stretch_req = stretch;
    rx.delete();
    req = r;
    t = 0;
    while (gnt == 2'b00 && t < 200) begin @(negedge clk); t++; end
    if (gnt == 2'b00) begin
      check("grant_timeout", 32'(gnt), 32'(exp_grant(r)));
      req = 2'b00;
      return;
    end
    gcyc = cyc;
    eg = exp_grant(r);
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'd1);
    if (have_done) check("gap", 32'(gcyc - last_done_cyc >= GAP_Q * CLK_DIV), 32'd1);
    ea = (eg == 2'b01) ? a0 : a1;
    ed = (eg == 2'b01) ? d0 : d1;
    if (perturb) begin
      @(negedge clk);
      addr0 = 7'($urandom); data0 = 8'($urandom);
      addr1 = 7'($urandom); data1 = 8'($urandom);
    end
    t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    dcyc = cyc;
    exp_lat = (2 + ((mode == 1) ? 36 : 72) + 3) * CLK_DIV + (stretch ? STRETCH : 0);
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(dcyc - gcyc), 32'(exp_lat));
    check("nack", 32'(nack), 32'(mode != 0));
    check("rx_count", 32'(rx.size()), (mode == 1) ? 32'd1 : 32'd2);
    if (rx.size() >= 1) check("addr_byte", 32'(rx[0]), 32'({ea, 1'b0}));
    if (rx.size() >= 2) check("data_byte", 32'(rx[1]), 32'(ed));
    last_srv = (eg == 2'b01) ? 0 : 1;
    last_done_cyc = dcyc;
    have_done = 1;
    req = r & ~eg;
    @(negedge clk);
    check("gnt_clr", 32'(gnt), 32'd0);
    check("busy_clr", 32'(busy), 32'd0);
    check("nack_hold", 32'(nack), 32'(mode != 0));
  endtask

  initial begin
    int t;
    reset = 1'b1; req = '0;
    addr0 = '0; data0 = '0; addr1 = '0; data1 = '0;
    ack_addr = 1'b1; ack_data = 1'b1; stretch_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst_scl", 32'(scl_o), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_txn(2'b01, 7'h4A, 8'hA5, 7'h11, 8'h22, 0, 1'b0, 1'b0);
    do_txn(2'b01, 7'h23, 8'h5C, 7'h11, 8'h22, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      do_txn(2'b11, 7'($urandom), 8'($urandom), 7'($urandom), 8'($urandom), 0, 1'b0, 1'b0);
    do_txn(2'b01, 7'h4A, 8'h3C, 7'h00, 8'h00, 0, 1'b1, 1'b0);
    do_txn(2'b01, 7'h55, 8'hC3, 7'h2A, 8'h81, 0, 1'b0, 1'b1);
    do_txn(2'b10, 7'h2B, 8'h99, 7'h6E, 8'h17, 2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      do_txn(2'($urandom_range(1, 3)), 7'($urandom), 8'($urandom), 7'($urandom), 8'($urandom),
             int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'($urandom));

    // Reset part-way through a transfer, then a fresh transfer.
    req = 2'b01; addr0 = 7'h4A; data0 = 8'hF0; ack_addr = 1'b1; ack_data = 1'b1; stretch_req = 1'b0;
    t = 0;
    while (gnt == 2'b00 && t < 200) begin @(negedge clk); t++; end
    check("pre_rst_gnt", 32'(gnt), 32'd1);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_scl", 32'(scl_o), 32'd1);
    check("mid_rst_sda", 32'(sda_o), 32'd1);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    req = 2'b00;
    last_srv = 1;
    have_done = 0;
    @(negedge clk);
    do_txn(2'b01, 7'h4A, 8'h5A, 7'h10, 8'h01, 0, 1'b0, 1'b0);
    do_txn(2'b11, 7'h12, 8'h34, 7'h56, 8'h78, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
